// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-bit shift sequencer.
//   state_t           : controller FSM states
//   SHIFT_OP_*        : op encodings understood by the single-bit shift unit
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [1:0] SHIFT_OP_A_RIGHT = 2'b00;
  localparam logic [1:0] SHIFT_OP_A_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_OP_B_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_OP_B_LEFT  = 2'b11;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter for the remaining shift steps.
// The load value is the requested amount clamped to WIDTH.
//   CLK, RST : clock, asynchronous active-low reset
//   load_i   : load clamped amt_i
//   amt_i    : requested shift amount
//   dec_i    : decrement by one (saturates at zero)
//   zero_o   : the count being written this cycle is zero
module shift_seq_cnt #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      if (32'(amt_i) > 32'(WIDTH)) cnt_d = CNT_W'(WIDTH);
      else                         cnt_d = CNT_W'(amt_i);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Looking at the next value lets the FSM decide on the same cycle it
  // loads or decrements, without a wasted check cycle.
  assign zero_o = (cnt_d == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer: accepts one (operand, direction, amount)
// request, steps the single-bit shift unit once per bit position and
// returns the final value.
// Build option: SHIFT_SEQ_FLAG_CHECK_EN -- when defined, a missing SU_Flag
// in CAPTURE aborts the sequence with rsp_err=1; otherwise SU_Flag is
// ignored and rsp_err is always 0.
//   CLK, RST                       : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake
//   req_data, req_dir, req_amt     : operand, 0=right 1=left, bit count
//   SU_A, SU_B, SU_Op, SU_Enable   : shift unit drive
//   SU_Out, SU_Flag                : shift unit registered result/flag
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data, rsp_err              : result, abort indication
//   busy                           : controller not IDLE
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_dir,
  input  logic [AMT_W-1:0] req_amt,
  output logic [WIDTH-1:0] SU_A,
  output logic [WIDTH-1:0] SU_B,
  output logic [1:0]       SU_Op,
  output logic             SU_Enable,
  input  logic [WIDTH-1:0] SU_Out,
  input  logic             SU_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic             dir_q,   dir_d;
  logic             err_q,   err_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign cnt_load = (state_q == IDLE) && req_valid;
  assign cnt_dec  = (state_q == CAPTURE);

  shift_seq_cnt #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (cnt_load),
    .amt_i  (req_amt),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

`ifndef SHIFT_SEQ_FLAG_CHECK_EN
  logic unused_flag;
  assign unused_flag = SU_Flag;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          work_d  = req_data;
          dir_d   = req_dir;
          err_d   = 1'b0;
          state_d = cnt_zero ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
`ifdef SHIFT_SEQ_FLAG_CHECK_EN
        if (!SU_Flag) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          work_d  = SU_Out;
          state_d = cnt_zero ? DONE : ISSUE;
        end
`else
        work_d  = SU_Out;
        state_d = cnt_zero ? DONE : ISSUE;
`endif
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      work_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  // Shift unit pins are a pure decode of the state; only ISSUE drives them.
  always_comb begin
    SU_A      = '0;
    SU_Op     = SHIFT_OP_A_RIGHT;
    SU_Enable = 1'b0;
    if (state_q == ISSUE) begin
      SU_A      = work_q;
      SU_Op     = dir_q ? SHIFT_OP_A_LEFT : SHIFT_OP_A_RIGHT;
      SU_Enable = 1'b1;
    end
  end

  assign SU_B      = '0;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = work_q;
  assign rsp_err   = err_q;

endmodule
